game_state_keeper: RTL
======================

# game_state_keeper

Holds the live 134-bit Sokoban board state and a bounded undo history. It sits between the game controller and the move logic. On the controller's `game_state_en`/`sel` commands it does one of three things: reloads the current stage map, commits a computed move, or retracts the last move. It feeds `game_state` back to the controller, the move logic and the renderer.

## Interface

- `DEPTH`, default 8: number of undo entries; must be a power of two, ≥ 2.
- `AW`, default 3: pointer width, equal to log2(`DEPTH`).
- `SW`, default 10: width of the step counter.

- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  one clock; reset is synchronous and active-low.
- `game_state_en`  input  1  command strobe from the game controller; `sel` is acted on only when this is high.
- `sel`  input  2  command: 0 = load stage, 1 = commit move, 2 = hold, 3 = retract.
- `stage_map`  input  134  initial state of the current stage, from the level ROM.
- `move_state`  input  134  next state computed by the move logic.
- `game_state`  output  134  current board state. Fields are `way` [133:70], `box` [69:6] and player cursor [5:0].
- `history_count`  output  AW+1  number of valid undo entries, 0..`DEPTH`.
- `history_empty`  output  1  high when `history_count` == 0.
- `steps`  output  SW  number of moves in the current attempt.

## Operation

**Storage**
- `hist[0..DEPTH-1]`: each entry is 134 bits.
- `wp`: AW-bit write pointer.
- `cnt`: AW+1-bit count of valid entries.
- Current state lives in register `cur`, which drives `game_state`.

**Reset** (`reset`=0 at a clock edge)
- `cur`=0, `wp`=0, `cnt`=0, `steps`=0.
- `history_empty`=1.
- `hist` contents are don't-care.

**Commands** (evaluated only when `game_state_en`=1; otherwise every register holds)

- **`sel`=0, load:**
  - `cur` ← `stage_map`.
  - `wp` ← 0, `cnt` ← 0, `steps` ← 0.
  - `hist` is not written.
- **`sel`=1, commit:**
  - `hist[wp]` ← old `cur`, and `cur` ← `move_state`.
  - `wp` ← `wp`+1, wrapping mod `DEPTH`.
  - `cnt` ← min(`cnt`+1, `DEPTH`).
  - `steps` ← `steps`+1, saturating at 2^SW−1.
- **`sel`=3, retract with `cnt`>0:**
  - `cur` ← `hist[wp−1]` (index mod `DEPTH`).
  - `wp` ← `wp`−1, `cnt` ← `cnt`−1.
  - `steps` ← `steps`−1, saturating at 0.
- **`sel`=3, retract with `cnt`=0:** no change to any register.
- **`sel`=2:** no change to any register.

**History behaviour**
- The history is a circular LIFO. When `cnt`=`DEPTH`, a commit overwrites the oldest entry, which sits at the current `wp`. `cnt` stays at `DEPTH`.
- Only the last `DEPTH` moves can be retracted. `steps` is not limited by `DEPTH`, so after deep undo `steps` can be greater than 0 while `cnt` is 0.
- `move_state` and `stage_map` are sampled only on their respective commands. The block never inspects their contents.

## Timing

- Every output is a register; there is no combinational path from inputs to outputs.
- A command sampled at edge N is visible on `game_state`, `history_count` and `steps` after edge N.
- The controller issues each command as a single-cycle strobe. Back-to-back strobes on consecutive cycles are legal, and each is applied in order.
- A commit reads `cur` before it updates. Commit followed by retract on the next cycle restores the pre-commit state exactly.
- Reset has priority over any command in the same cycle.
- A reset mid-sequence discards all history. The controller then issues a load (`sel`=0, en=1) in its RESET/INIT states.
- Retract on an empty history in the same cycle as reset: reset wins.

## Test plan

1. **Reset then load.** Hold `reset`=0 for 2 cycles, release, then apply en=1, `sel`=0 with `stage_map`=A.
   - Next cycle: `game_state`=A, `history_count`=0, `history_empty`=1, `steps`=0.
2. **Commit then retract.** From state A, commit B, then commit C, then retract twice.
   - After the commits, `game_state` goes B then C, with `steps` 1, 2 and `history_count` 1, 2.
   - After the retracts, `game_state` goes B then A, with `steps` 1, 0 and `history_empty`=1.
3. **Overflow wrap.** With `DEPTH`=8, load A, then commit S1..S10.
   - `history_count`=8 and `steps`=10.
   - Eight retracts give S9, S8, …, S2 in order.
   - A ninth retract leaves S2 unchanged, with `history_empty`=1 and `steps`=2.
4. **Gating.** Pulse each of `sel`=0, 1 and 3 with en=0, then `sel`=2 with en=1.
   - `game_state`, `history_count` and `steps` remain unchanged in every case.
5. **Retry mid-game.** Load A, commit 3 moves, then load A again.
   - `game_state`=A, `history_count`=0, `steps`=0.
   - A subsequent retract produces no change.
6. **Reset priority.** `reset`=0 in the same cycle as en=1, `sel`=1.
   - `game_state`=0 and `steps`=0; `move_state` is not captured.

Source files
------------

// File: rtl/game_state_keeper.sv
// Live Sokoban board state with a circular undo history.
// Load, commit and retract commands arrive as single-cycle strobes from the game controller.
module game_state_keeper #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int SW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          game_state_en,
  input  logic [1:0]    sel,
  input  logic [133:0]  stage_map,
  input  logic [133:0]  move_state,
  output logic [133:0]  game_state,
  output logic [AW:0]   history_count,
  output logic          history_empty,
  output logic [SW-1:0] steps
);

  localparam logic [1:0]  CMD_LOAD    = 2'd0;
  localparam logic [1:0]  CMD_COMMIT  = 2'd1;
  localparam logic [1:0]  CMD_RETRACT = 2'd3;
  localparam logic [AW:0] CNT_FULL    = (AW+1)'(DEPTH);

  logic [133:0]  hist [DEPTH];
  logic [133:0]  cur_reg, cur_next;
  logic [133:0]  top_reg;
  logic [AW-1:0] wp_reg, wp_next;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   cnt_reg, cnt_next;
  logic [SW-1:0] steps_reg, steps_next;
  logic          empty_reg;
  logic          hist_we;

  always_comb begin
    cur_next   = cur_reg;
    wp_next    = wp_reg;
    cnt_next   = cnt_reg;
    steps_next = steps_reg;
    hist_we    = 1'b0;
    if (game_state_en) begin
      case (sel)
        CMD_LOAD: begin
          cur_next   = stage_map;
          wp_next    = '0;
          cnt_next   = '0;
          steps_next = '0;
        end
        CMD_COMMIT: begin
          hist_we  = 1'b1;
          cur_next = move_state;
          wp_next  = wp_reg + 1'b1;
          if (cnt_reg != CNT_FULL) cnt_next = cnt_reg + 1'b1;
          if (steps_reg != '1) steps_next = steps_reg + 1'b1;
        end
        CMD_RETRACT: begin
          if (cnt_reg != '0) begin
            cur_next = top_reg;
            wp_next  = wp_reg - 1'b1;
            cnt_next = cnt_reg - 1'b1;
            if (steps_reg != '0) steps_next = steps_reg - 1'b1;
          end
        end
        default: ;
      endcase
    end
    // top_reg always holds the entry a retract on the next cycle would restore
    rd_addr = wp_next - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_reg   <= '0;
      wp_reg    <= '0;
      cnt_reg   <= '0;
      steps_reg <= '0;
      empty_reg <= 1'b1;
    end else begin
      cur_reg   <= cur_next;
      wp_reg    <= wp_next;
      cnt_reg   <= cnt_next;
      steps_reg <= steps_next;
      empty_reg <= (cnt_next == '0);
    end
  end

  // History RAM with registered read; a commit's own write is forwarded into top_reg.
  always_ff @(posedge clk) begin
    if (reset && hist_we) hist[wp_reg] <= cur_reg;
    if (hist_we) top_reg <= cur_reg;
    else         top_reg <= hist[rd_addr];
  end

  assign game_state    = cur_reg;
  assign history_count = cnt_reg;
  assign history_empty = empty_reg;
  assign steps         = steps_reg;

endmodule
